// File: rtl/hs_byte_packer_if.sv
// hs_byte_packer_if
//   Bundles the byte-side and word-side handshake signals of hs_byte_packer.
//   Signal suffixes are from the packer's point of view.
//   Ports / signals:
//     valid_pre_i, data_pre_i, ready_pre_o : 8-bit upstream valid/ready handshake
//     flush_i                              : single-cycle request to emit a partial word
//     valid_post_o, data_post_o,
//     keep_post_o, ready_post_i            : downstream word handshake with byte-keep mask
//   Modports:
//     slave  : used by the packer itself
//     master : used by whatever drives the packer (upstream + downstream environment)
interface hs_byte_packer_if #(
    parameter int BEATS = 4
);
    logic                 valid_pre_i;
    logic [7:0]           data_pre_i;
    logic                 ready_pre_o;
    logic                 flush_i;
    logic                 valid_post_o;
    logic [8*BEATS-1:0]   data_post_o;
    logic [BEATS-1:0]     keep_post_o;
    logic                 ready_post_i;

    modport slave (
        input  valid_pre_i,
        input  data_pre_i,
        input  flush_i,
        input  ready_post_i,
        output ready_pre_o,
        output valid_post_o,
        output data_post_o,
        output keep_post_o
    );

    modport master (
        output valid_pre_i,
        output data_pre_i,
        output flush_i,
        output ready_post_i,
        input  ready_pre_o,
        input  valid_post_o,
        input  data_post_o,
        input  keep_post_o
    );
endinterface

// File: rtl/hs_byte_packer.sv
// hs_byte_packer
//   Packs BEATS consecutive bytes (little-endian, byte 0 in bits [7:0]) into one
//   wide word presented on a registered valid/ready output with a contiguous
//   byte-keep mask. A flush request emits a partially filled word early; if the
//   output register is busy the flush is held pending and upstream is stalled.
//   Ports:
//     clk    : sole clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : hs_byte_packer_if.slave (byte input, flush, word output)
module hs_byte_packer #(
    parameter int BEATS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    hs_byte_packer_if.slave   bus
);
    localparam int            CW       = $clog2(BEATS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [8*(BEATS-1)-1:0] acc_q, acc_d;
    logic                   fpend_q, fpend_d;
    logic                   valid_q, valid_d;
    logic [8*BEATS-1:0]     data_q, data_d;
    logic [BEATS-1:0]       keep_q, keep_d;

    logic                   slot;
    logic                   ready_pre;
    logic                   acc_in;
    logic                   complete;
    logic                   flush_any;
    logic [CW:0]            n_bytes;
    logic [BEATS-1:0]       part_keep;

    always_comb begin
        slot      = !valid_q || bus.ready_post_i;
        // The last lane is only accepted when the word can go straight out,
        // so a completing byte never has to wait inside the packer.
        ready_pre = !fpend_q && ((cnt_q != CNT_LAST) || slot);
        acc_in    = bus.valid_pre_i && ready_pre;
        complete  = acc_in && (cnt_q == CNT_LAST);
        flush_any = bus.flush_i || fpend_q;
        n_bytes   = {1'b0, cnt_q} + {{CW{1'b0}}, acc_in};
        part_keep = (BEATS'(1) << n_bytes) - BEATS'(1);

        acc_d   = acc_q;
        cnt_d   = cnt_q;
        fpend_d = fpend_q;
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;

        if (valid_q && bus.ready_post_i) begin
            valid_d = 1'b0;
        end

        if (acc_in && !complete) begin
            for (int i = 0; i < BEATS - 1; i++) begin
                if (cnt_q == CW'(i)) begin
                    acc_d[8*i +: 8] = bus.data_pre_i;
                end
            end
            cnt_d = cnt_q + CW'(1);
        end

        if (complete) begin
            // A full word also satisfies any flush in flight.
            data_d  = {bus.data_pre_i, acc_q};
            keep_d  = '1;
            valid_d = 1'b1;
            cnt_d   = '0;
            fpend_d = 1'b0;
        end else if (flush_any) begin
            if (n_bytes == '0) begin
                fpend_d = 1'b0;
            end else if (slot) begin
                // acc_d already includes a byte accepted this cycle; stale
                // lanes beyond n_bytes are forced to zero.
                data_d = '0;
                for (int i = 0; i < BEATS - 1; i++) begin
                    if (part_keep[i]) begin
                        data_d[8*i +: 8] = acc_d[8*i +: 8];
                    end
                end
                keep_d  = part_keep;
                valid_d = 1'b1;
                cnt_d   = '0;
                fpend_d = 1'b0;
            end else begin
                fpend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            fpend_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            fpend_q <= fpend_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
        end
    end

    assign bus.ready_pre_o  = ready_pre;
    assign bus.valid_post_o = valid_q;
    assign bus.data_post_o  = data_q;
    assign bus.keep_post_o  = keep_q;
endmodule

// File: tb/tb_hs_byte_packer.sv
module tb_hs_byte_packer;
    localparam int BEATS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hs_byte_packer_if #(.BEATS(BEATS)) bus ();

    hs_byte_packer #(.BEATS(BEATS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } word_t;

    word_t       exp_q[$];
    word_t       exp_w;
    int          checks      = 0;
    int          errors      = 0;
    int          send_waits  = 0;
    logic        hold_chk    = 1'b0;
    logic [31:0] hold_data   = '0;
    logic [3:0]  hold_keep   = '0;

    // Scoreboard monitor: every word transfer pops one expectation; a stalled
    // word must stay put until it transfers.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_chk = 1'b0;
            end else begin
                if (hold_chk) begin
                    checks++;
                    if (bus.valid_post_o !== 1'b1 || bus.data_post_o !== hold_data ||
                        bus.keep_post_o !== hold_keep) begin
                        errors++;
                        $display("FAIL stall_stable: got valid=%b data=%h keep=%b, need valid=1 data=%h keep=%b",
                                 bus.valid_post_o, bus.data_post_o, bus.keep_post_o, hold_data, hold_keep);
                    end
                end
                if (bus.valid_post_o && bus.ready_post_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: got data=%h keep=%b, need no word",
                                 bus.data_post_o, bus.keep_post_o);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (bus.data_post_o !== exp_w.data || bus.keep_post_o !== exp_w.keep) begin
                            errors++;
                            $display("FAIL word: got data=%h keep=%b, need data=%h keep=%b",
                                     bus.data_post_o, bus.keep_post_o, exp_w.data, exp_w.keep);
                        end
                    end
                end
                hold_chk  = bus.valid_post_o && !bus.ready_post_i;
                hold_data = bus.data_post_o;
                hold_keep = bus.keep_post_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, need completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        bus.valid_pre_i = 1'b1;
        bus.data_pre_i  = b;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (bus.ready_pre_o) ok = 1'b1;
            else send_waits++;
            @(posedge clk);
            #1;
        end
        bus.valid_pre_i = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: got no accept for byte %h, need accept within 64 cycles", b);
        end
    endtask

    task automatic drain_wait();
        for (int k = 0; k < 64 && exp_q.size() != 0; k++) @(negedge clk);
        tick();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus.valid_post_o !== 1'b0 || bus.data_post_o !== 32'h0 || bus.keep_post_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h keep=%b, need 0/0/0",
                     bus.valid_post_o, bus.data_post_o, bus.keep_post_o);
        end
        checks++;
        if (bus.ready_pre_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, need 1", bus.ready_pre_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.valid_post_o !== 1'b0 || bus.ready_pre_o !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: got valid=%b ready=%b, need 0/1",
                     bus.valid_post_o, bus.ready_pre_o);
        end
        tick();
    endtask

    task automatic test_full_rate();
        logic [7:0] bytes_a [4];
        bytes_a[0] = 8'h11; bytes_a[1] = 8'h22; bytes_a[2] = 8'h33; bytes_a[3] = 8'h44;
        bus.ready_post_i = 1'b1;
        exp_q.push_back({32'h44332211, 4'b1111});
        for (int i = 0; i < 4; i++) begin
            bus.valid_pre_i = 1'b1;
            bus.data_pre_i  = bytes_a[i];
            @(negedge clk);
            checks++;
            if (bus.ready_pre_o !== 1'b1) begin
                errors++;
                $display("FAIL full_rate_ready: got %b at byte %0d, need 1", bus.ready_pre_o, i);
            end
            tick();
        end
        bus.valid_pre_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valid_post_o !== 1'b1 || bus.data_post_o !== 32'h44332211 || bus.keep_post_o !== 4'b1111) begin
            errors++;
            $display("FAIL full_rate_word: got valid=%b data=%h keep=%b, need 1/44332211/1111",
                     bus.valid_post_o, bus.data_post_o, bus.keep_post_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.valid_post_o !== 1'b0) begin
            errors++;
            $display("FAIL full_rate_one_cycle: got valid=%b, need 0", bus.valid_post_o);
        end
        drain_wait();
    endtask

    task automatic test_stall();
        bus.ready_post_i = 1'b0;
        exp_q.push_back({32'h04030201, 4'b1111});
        exp_q.push_back({32'h08070605, 4'b1111});
        for (int i = 1; i <= 7; i++) send_byte(8'(i));
        bus.valid_pre_i = 1'b1;
        bus.data_pre_i  = 8'h08;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.ready_pre_o !== 1'b0 || bus.valid_post_o !== 1'b1 || bus.data_post_o !== 32'h04030201) begin
                errors++;
                $display("FAIL stall_hold: got ready=%b valid=%b data=%h, need 0/1/04030201",
                         bus.ready_pre_o, bus.valid_post_o, bus.data_post_o);
            end
            tick();
        end
        bus.ready_post_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ready_pre_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b, need 1", bus.ready_pre_o);
        end
        tick();
        bus.valid_pre_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valid_post_o !== 1'b1 || bus.data_post_o !== 32'h08070605) begin
            errors++;
            $display("FAIL stall_second_word: got valid=%b data=%h, need 1/08070605",
                     bus.valid_post_o, bus.data_post_o);
        end
        drain_wait();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: got %0d words outstanding, need 0", exp_q.size());
        end
    endtask

    task automatic test_partial_flush();
        bus.ready_post_i = 1'b1;
        send_byte(8'hAA);
        send_byte(8'hBB);
        exp_q.push_back({32'h0000BBAA, 4'b0011});
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valid_post_o !== 1'b1 || bus.data_post_o !== 32'h0000BBAA || bus.keep_post_o !== 4'b0011) begin
            errors++;
            $display("FAIL partial_flush: got valid=%b data=%h keep=%b, need 1/0000bbaa/0011",
                     bus.valid_post_o, bus.data_post_o, bus.keep_post_o);
        end
        drain_wait();
    endtask

    task automatic test_flush_accept();
        bus.ready_post_i = 1'b1;
        send_byte(8'h5A);
        send_byte(8'h6B);
        exp_q.push_back({32'h00CC6B5A, 4'b0111});
        bus.valid_pre_i = 1'b1;
        bus.data_pre_i  = 8'hCC;
        bus.flush_i     = 1'b1;
        tick();
        bus.valid_pre_i = 1'b0;
        bus.flush_i     = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valid_post_o !== 1'b1 || bus.data_post_o !== 32'h00CC6B5A || bus.keep_post_o !== 4'b0111) begin
            errors++;
            $display("FAIL flush_with_accept: got valid=%b data=%h keep=%b, need 1/00cc6b5a/0111",
                     bus.valid_post_o, bus.data_post_o, bus.keep_post_o);
        end
        drain_wait();

        send_byte(8'h91);
        send_byte(8'h92);
        send_byte(8'h93);
        exp_q.push_back({32'h94939291, 4'b1111});
        bus.valid_pre_i = 1'b1;
        bus.data_pre_i  = 8'h94;
        bus.flush_i     = 1'b1;
        tick();
        bus.valid_pre_i = 1'b0;
        bus.flush_i     = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valid_post_o !== 1'b1 || bus.data_post_o !== 32'h94939291 || bus.keep_post_o !== 4'b1111) begin
            errors++;
            $display("FAIL flush_with_complete: got valid=%b data=%h keep=%b, need 1/94939291/1111",
                     bus.valid_post_o, bus.data_post_o, bus.keep_post_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.valid_post_o !== 1'b0 || bus.ready_pre_o !== 1'b1) begin
            errors++;
            $display("FAIL no_empty_word: got valid=%b ready=%b, need 0/1",
                     bus.valid_post_o, bus.ready_pre_o);
        end
        drain_wait();
    endtask

    task automatic test_flush_stalled();
        bus.ready_post_i = 1'b0;
        exp_q.push_back({32'h24232221, 4'b1111});
        for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i));
        exp_q.push_back({32'h00000025, 4'b0001});
        send_byte(8'h25);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.ready_pre_o !== 1'b0 || bus.data_post_o !== 32'h24232221) begin
                errors++;
                $display("FAIL flush_pending: got ready=%b data=%h, need 0/24232221",
                         bus.ready_pre_o, bus.data_post_o);
            end
            tick();
        end
        bus.ready_post_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ready_pre_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_pending_release: got ready=%b, need 0", bus.ready_pre_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.valid_post_o !== 1'b1 || bus.data_post_o !== 32'h00000025 ||
            bus.keep_post_o !== 4'b0001 || bus.ready_pre_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_stalled_word: got valid=%b data=%h keep=%b ready=%b, need 1/00000025/0001/1",
                     bus.valid_post_o, bus.data_post_o, bus.keep_post_o, bus.ready_pre_o);
        end
        tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.valid_post_o !== 1'b0 || bus.ready_pre_o !== 1'b1) begin
                errors++;
                $display("FAIL empty_flush: got valid=%b ready=%b, need 0/1",
                         bus.valid_post_o, bus.ready_pre_o);
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL flush_stalled_drain: got %0d words outstanding, need 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bus.ready_post_i = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'h31 + 8'(i));
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.valid_post_o !== 1'b0 || bus.data_post_o !== 32'h0 ||
            bus.keep_post_o !== 4'h0 || bus.ready_pre_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b data=%h keep=%b ready=%b, need 0/0/0/1",
                     bus.valid_post_o, bus.data_post_o, bus.keep_post_o, bus.ready_pre_o);
        end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.ready_post_i = 1'b1;
        exp_q.push_back({32'h44434241, 4'b1111});
        for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i));
        @(negedge clk);
        checks++;
        if (bus.valid_post_o !== 1'b1 || bus.data_post_o !== 32'h44434241) begin
            errors++;
            $display("FAIL reset_mid_new_word: got valid=%b data=%h, need 1/44434241",
                     bus.valid_post_o, bus.data_post_o);
        end
        drain_wait();
    endtask

    task automatic test_back_to_back();
        bus.ready_post_i = 1'b1;
        send_waits = 0;
        exp_q.push_back({32'hD4C3B2A1, 4'b1111});
        exp_q.push_back({32'h0F0E0D0C, 4'b1111});
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        send_byte(8'h0C); send_byte(8'h0D); send_byte(8'h0E); send_byte(8'h0F);
        checks++;
        if (send_waits != 0) begin
            errors++;
            $display("FAIL back_to_back_bubbles: got %0d wait cycles, need 0", send_waits);
        end
        drain_wait();
    endtask

    task automatic test_random_backpressure();
        logic        done;
        logic [31:0] wbuf;
        logic [7:0]  b;
        done = 1'b0;
        wbuf = '0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    b = 8'($urandom_range(0, 255));
                    wbuf[8*(i%4) +: 8] = b;
                    if (i % 4 == 3) exp_q.push_back({wbuf, 4'b1111});
                    send_byte(b);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.ready_post_i = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        bus.ready_post_i = 1'b1;
        drain_wait();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d words outstanding, need 0", exp_q.size());
        end
    endtask

    initial begin
        bus.valid_pre_i  = 1'b0;
        bus.data_pre_i   = 8'h00;
        bus.flush_i      = 1'b0;
        bus.ready_post_i = 1'b1;
        test_reset();
        test_full_rate();
        test_stall();
        test_partial_flush();
        test_flush_accept();
        test_flush_stalled();
        test_reset_mid();
        test_back_to_back();
        test_random_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hs_byte_packer.md
# hs_byte_packer

Downstream width-converting stage for the 8-bit valid/ready handshake pipeline. It accepts bytes from the preceding buffered handshake stage, packs `BEATS` consecutive bytes little-endian into one wide word, and presents the word on a registered valid/ready output with a byte-keep mask. A flush request emits a partially filled word early.

## Interface
- `BEATS`, default 4: bytes per output word; must be a power of two, ≥ 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_pre_i`  in  1  byte valid from the upstream stage.
- `data_pre_i`  in  8  byte from the upstream stage.
- `ready_pre_o`  out  1  byte accepted when `valid_pre_i && ready_pre_o`.
- `flush_i`  in  1  single-cycle flush request; latched internally.
- `valid_post_o`  out  1  word valid to the downstream stage; registered.
- `data_post_o`  out  8*BEATS  packed word; byte 0 in bits [7:0]; registered.
- `keep_post_o`  out  BEATS  per-byte valid mask, contiguous from bit 0; registered.
- `ready_post_i`  in  1  downstream ready.

## Operation
- **State.**
  - `acc` holds BEATS-1 bytes.
  - `cnt` holds 0..BEATS-1 and counts bytes held in `acc`.
  - `fpend` is the latched flush request.
  - The output register holds `valid_post_o`, `data_post_o` and `keep_post_o`.
- **Derived terms.**
  - `slot = !valid_post_o || ready_post_i`: the output register can load this cycle.
  - `acc_in = valid_pre_i && ready_pre_o`.
  - `f = flush_i || fpend`.
  - `n = cnt + acc_in`.
- `ready_pre_o = !fpend && (cnt != BEATS-1 || slot)`. It is combinational from `ready_post_i`. This path is permitted because the upstream stage's ready is itself registered.
- **Accept, not completing** (`acc_in`, `cnt < BEATS-1`): write the byte into lane `cnt` of `acc`, then `cnt <= cnt+1`.
- **Complete** (`acc_in`, `cnt == BEATS-1`; `slot` is guaranteed):
  - Load the output with `{data_pre_i, acc}` and keep all ones.
  - Set `valid_post_o <= 1` and `cnt <= 0`.
  - Clear `fpend`, since the flush is satisfied by this word.
- **Flush** (`f`, no complete this cycle):
  - If `n == 0`: clear `fpend`; no output.
  - Else if `slot`: load the output with the `n` held bytes, including any byte accepted this cycle. Unused lanes are 0 and `keep = (1<<n)-1`. Set `cnt <= 0` and `fpend <= 0`.
  - Else: set `fpend <= 1`. Any byte accepted this cycle is still stored in `acc`.
- **Output drain.** If `valid_post_o && ready_post_i` and nothing loads this cycle, `valid_post_o <= 0`. Data and keep retain their values.
- A `flush_i` pulse arriving while `fpend` is already set is absorbed; only one partial word results.

## Timing
- **Reset** (asynchronous, active-low):
  - `valid_post_o`, `data_post_o`, `keep_post_o`, `cnt`, `acc` and `fpend` = 0.
  - `ready_pre_o` = 1 during and after reset.
- **Latency:** the completing byte accepted at edge t gives `valid_post_o` = 1 after edge t. Word data is present in the same cycle.
- **Throughput:** one byte per cycle sustained with `ready_post_i` high; a full word every BEATS cycles, with no bubbles.
- **Stability:**
  - While `valid_post_o && !ready_post_i`, `data_post_o` and `keep_post_o` are stable.
  - `valid_post_o` never drops without a transfer.
- **Back-pressure:** when `cnt == BEATS-1` and the output is stalled, `ready_pre_o` = 0 until the cycle `ready_post_i` = 1.
- **Pending flush:** while `fpend` = 1, `ready_pre_o` = 0. The partial word loads on the first cycle with `slot`.
- **Reset mid-operation:** partial `acc` contents and any held output word are discarded, with no flush emitted.

## Test plan
- **Full-rate packing:** BEATS=4, bytes 0x11,0x22,0x33,0x44 on consecutive cycles with `ready_post_i`=1 → one cycle after the fourth byte, `data_post_o`=0x44332211 and `keep_post_o`=4'b1111 for 1 cycle; `ready_pre_o` stays 1 throughout.
- **Stall:** 8 bytes 0x01..0x08 with `ready_post_i`=0 from the first word onward → `ready_pre_o` drops with `cnt`=3 and the 4th byte of word 2 pending; word 0x04030201 is held stable. Raising `ready_post_i` transfers it, then 0x08070605 follows one cycle later; no byte is lost or duplicated.
- **Partial flush:** bytes 0xAA,0xBB, then a `flush_i` pulse with no byte → `data_post_o`=0x0000BBAA, `keep_post_o`=4'b0011; the next word starts at lane 0.
- **Flush coinciding with an accept:** `cnt`=2 and byte 0xCC accepted in the same cycle as `flush_i` → keep=4'b0111 with 0xCC in lane 2. Flush together with a completing 4th byte → exactly one full word, keep=4'b1111, and no extra empty word.
- **Flush while stalled:** output full, `ready_post_i`=0, `cnt`=1, `flush_i` pulsed → `ready_pre_o`=0 until the stall clears. The held word transfers, then the partial word (keep=4'b0001) appears next cycle. A flush with `cnt`=0 produces no output.
- **Reset mid-word:** `rst_n` asserted asynchronously with `cnt`=2 and `valid_post_o`=1 → all outputs 0 immediately; after release, 4 new bytes produce a word with only new data.
